// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: sole owner of the register file write port.
//
// After reset, and again on Clear, sweeps INIT_VALUE into every register.
// It then shares the write port between two requesters with round-robin
// arbitration and a req/ack handshake.
//
// Ports:
//   Clk, Reset            clock (rising edge), async active-low reset
//   Clear                 one-cycle pulse, restarts the init sweep
//   Req0/Addr0/Data0      requester 0 write request, address and data
//   Ack0                  one-cycle pulse, requester 0 write issued
//   Req1/Addr1/Data1      requester 1 write request, address and data
//   Ack1                  one-cycle pulse, requester 1 write issued
//   Reg_W_Addr, W_Data    register file write address and data (registered)
//   Write_Reg             register file write enable (registered)
//   Busy                  high while the init sweep runs
module reg_write_arbiter #(
  parameter int unsigned         NUM_REGS     = 32,
  parameter int unsigned         ADDR_W       = 5,
  parameter int unsigned         DATA_W       = 32,
  parameter logic [DATA_W-1:0]   INIT_VALUE   = '0,
  parameter bit                  ZERO_PROTECT = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Data0,
  output logic              Ack0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data1,
  output logic              Ack1,
  output logic [ADDR_W-1:0] Reg_W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Busy
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              last_q, last_d;
  logic              write_reg_q, write_reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              gnt0, gnt1;

  // On a tie, serve whoever was not served last; last_q resets to 1 so
  // requester 0 wins the first tie.
  assign gnt0 = Req0 & (~Req1 | last_q);
  assign gnt1 = Req1 & (~Req0 | ~last_q);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_reg_d = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        write_reg_d = 1'b1;
        data_d      = INIT_VALUE;
        if (Clear) begin
          addr_d     = '0;
          init_cnt_d = '0;
        end else begin
          addr_d = init_cnt_q;
          if (init_cnt_q == LastIdx) begin
            state_d    = S_RUN;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        if (Clear) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
        end else if (gnt0) begin
          addr_d      = Addr0;
          data_d      = Data0;
          ack0_d      = 1'b1;
          last_d      = 1'b0;
          // Register 0 is read-only to requesters: acknowledge, but don't write.
          write_reg_d = !(ZERO_PROTECT && (Addr0 == '0));
        end else if (gnt1) begin
          addr_d      = Addr1;
          data_d      = Data1;
          ack1_d      = 1'b1;
          last_d      = 1'b1;
          write_reg_d = !(ZERO_PROTECT && (Addr1 == '0));
        end
      end
      default: begin
        state_d    = S_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      last_q      <= 1'b1;
      write_reg_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      last_q      <= last_d;
      write_reg_q <= write_reg_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign Write_Reg  = write_reg_q;
  assign Reg_W_Addr = addr_q;
  assign W_Data     = data_q;
  assign Ack0       = ack0_q;
  assign Ack1       = ack1_q;
  assign Busy       = (state_q == S_INIT);

endmodule
